// File: rtl/match_checker_pkg.sv
// Shared types and helpers for the match_checker mismatch monitor.
package match_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Largest value a cnt_w-bit counter can hold; counters stop here instead of wrapping.
    function automatic longint unsigned sat_max(input int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/match_checker_sat_counter.sv
// Saturating up-counter with a clear that can count in the same cycle.
module sat_counter
    import match_checker_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] q_q, q_d;

    // Clear restarts from zero, but an increment in the clearing cycle still counts.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (q_q != MAX)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) q_q <= '0;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/match_checker.sv
// Reference-vs-DUT mismatch monitor: counts samples and mismatches over a window,
// captures the first mismatch index and a sticky per-bit mask, and reports pass/fail.
//
// state   | meaning
// IDLE    | no window yet, waiting for start
// RUN     | window open, every cycle is a sample
// DONE    | window closed, results held
module match_checker
    import match_checker_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] ref_val,
    input  logic [WIDTH-1:0] dut_val,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] clocks,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] err_mask
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] diff;
    logic             sample;
    logic             mismatch;
    logic [CNT_W-1:0] clocks_w;
    logic [CNT_W-1:0] errors_w;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic             first_valid_q, first_valid_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic [CNT_W-1:0] unused_bit0_errs;

    assign diff     = ref_val ^ dut_val;
    // The start cycle is always sample 0, whichever state it arrives in.
    assign sample   = start | (state_q == ST_RUN);
    assign mismatch = sample & (|diff);

    sat_counter #(.CNT_W(CNT_W)) u_clocks (
        .clk(clk), .aresetn(aresetn), .clr(start), .inc(sample), .q(clocks_w)
    );

    sat_counter #(.CNT_W(CNT_W)) u_errors (
        .clk(clk), .aresetn(aresetn), .clr(start), .inc(mismatch), .q(errors_w)
    );

    // Per-bit mismatch count for bit 0; groundwork for a per-bit breakdown.
    sat_counter #(.CNT_W(CNT_W)) u_bit0_errs (
        .clk(clk), .aresetn(aresetn), .clr(start), .inc(sample & diff[0]), .q(unused_bit0_errs)
    );

    // State register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: start always (re)opens a window; start+stop outside RUN is a 1-sample window.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = stop ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (start)     state_d = ST_RUN;
                else if (stop) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // First-mismatch capture and sticky mask; start clears and folds in sample 0.
    always_comb begin
        first_idx_d   = first_idx_q;
        first_valid_d = first_valid_q;
        err_mask_d    = err_mask_q;
        if (start) begin
            first_idx_d   = '0;
            first_valid_d = mismatch;
            err_mask_d    = diff;
        end else if (state_q == ST_RUN) begin
            err_mask_d = err_mask_q | diff;
            if (mismatch && !first_valid_q) begin
                first_idx_d   = clocks_w;
                first_valid_d = 1'b1;
            end
        end
    end

    // Capture registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
            err_mask_q    <= '0;
        end else begin
            first_idx_q   <= first_idx_d;
            first_valid_q <= first_valid_d;
            err_mask_q    <= err_mask_d;
        end
    end

    // Outputs decoded from registered state and counters.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (errors_w == '0);
    end

    assign clocks          = clocks_w;
    assign errors          = errors_w;
    assign first_err_idx   = first_idx_q;
    assign first_err_valid = first_valid_q;
    assign err_mask        = err_mask_q;

endmodule

// File: tb/tb_match_checker.sv
// Scoreboard bench for match_checker: a bench-side model predicts each window's
// results, pushes them when the closing stimulus is driven, and pops them after the edge.
module tb_match_checker;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] ref_val = '0;
    logic [W-1:0] dut_val = '0;

    logic         busy, done, pass, fev;
    logic [31:0]  clocks, errors, fidx;
    logic [W-1:0] mask;

    logic         s_busy, s_done, s_pass, s_fev;
    logic [3:0]   s_clocks, s_errors, s_fidx;
    logic [W-1:0] s_mask;

    match_checker #(.WIDTH(W), .CNT_W(32)) u_dut (
        .clk(clk), .aresetn(aresetn), .start(start), .stop(stop),
        .ref_val(ref_val), .dut_val(dut_val),
        .busy(busy), .done(done), .pass(pass), .clocks(clocks), .errors(errors),
        .first_err_idx(fidx), .first_err_valid(fev), .err_mask(mask)
    );

    match_checker #(.WIDTH(W), .CNT_W(4)) u_sat (
        .clk(clk), .aresetn(aresetn), .start(start), .stop(stop),
        .ref_val(ref_val), .dut_val(dut_val),
        .busy(s_busy), .done(s_done), .pass(s_pass), .clocks(s_clocks), .errors(s_errors),
        .first_err_idx(s_fidx), .first_err_valid(s_fev), .err_mask(s_mask)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        longint unsigned clocks;
        longint unsigned errors;
        longint unsigned idx;
        bit              valid;
        logic [W-1:0]    mask;
        bit              pass;
    } res_t;

    res_t exp_q[$];

    // Bench model of the 32-bit-counter instance (no saturation reachable here).
    int              m_state = 0;   // 0 idle, 1 run, 2 done
    longint unsigned m_clk, m_errs, m_idx;
    bit              m_valid;
    logic [W-1:0]    m_mask;

    task automatic model_clear();
        m_clk = 0; m_errs = 0; m_idx = 0; m_valid = 0; m_mask = '0;
    endtask

    task automatic do_reset();
        #3;
        aresetn = 1'b0;
        start = 1'b0; stop = 1'b0;
        m_state = 0;
        model_clear();
        exp_q.delete();
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_clocks", clocks, 0);
        check("rst_errors", errors, 0);
        check("rst_fidx", fidx, 0);
        check("rst_fev", fev, 0);
        check("rst_mask", mask, 0);
        @(posedge clk);
        #1;
        check("rst_hold_busy", busy, 0);
        aresetn = 1'b1;
    endtask

    // Drive one cycle; update the model; compare any window result due after the edge.
    task automatic cycle(input bit s, input bit p, input logic [W-1:0] r, input logic [W-1:0] d);
        bit   smp;
        int   nxt;
        res_t e;
        res_t g;
        start = s; stop = p; ref_val = r; dut_val = d;
        smp = s || (m_state == 1);
        if (s) model_clear();
        if (smp) begin
            if (r != d) begin
                if (!m_valid) begin
                    m_idx = m_clk;
                    m_valid = 1;
                end
                m_errs++;
                m_mask = m_mask | (r ^ d);
            end
            m_clk++;
        end
        nxt = m_state;
        if (s)                        nxt = (m_state != 1 && p) ? 2 : 1;
        else if (m_state == 1 && p)   nxt = 2;
        if (nxt == 2 && (m_state != 2 || s)) begin
            e.clocks = m_clk; e.errors = m_errs; e.idx = m_idx;
            e.valid = m_valid; e.mask = m_mask; e.pass = (m_errs == 0);
            exp_q.push_back(e);
        end
        m_state = nxt;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
        if (exp_q.size() != 0) begin
            g = exp_q.pop_front();
            check("win_done", done, 1);
            check("win_busy", busy, 0);
            check("win_pass", pass, g.pass);
            check("win_clocks", clocks, g.clocks);
            check("win_errors", errors, g.errors);
            check("win_fev", fev, g.valid);
            if (g.valid) check("win_fidx", fidx, g.idx);
            check("win_mask", mask, g.mask);
        end
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        do_reset();

        // All-match window of 20 samples.
        cycle(1, 0, 4'h0, 4'h0);
        check("t1_busy_rise", busy, 1);
        for (int i = 0; i < 18; i++) cycle(0, 0, 4'h0, 4'h0);
        cycle(0, 1, 4'h0, 4'h0);
        cycle(0, 1, 4'h0, 4'h0);
        check("t1_stop_ignored_clocks", clocks, 20);

        // Bit-2 mismatches on samples 5 and 9 of 12.
        for (int i = 0; i < 12; i++)
            cycle(i == 0, i == 11, 4'hA, (i == 5 || i == 9) ? 4'hE : 4'hA);

        // start and stop together from IDLE with a mismatch: 1-sample window.
        do_reset();
        cycle(1, 1, 4'h3, 4'h5);
        check("t3_busy_never", busy, 0);

        // Saturation on the 4-bit-counter instance; the 32-bit one tracks the full count.
        for (int i = 0; i < 20; i++) cycle(i == 0, i == 19, 4'h0, 4'h1);
        check("sat_done", s_done, 1);
        check("sat_clocks", s_clocks, 15);
        check("sat_errors", s_errors, 15);
        check("sat_pass", s_pass, 0);
        check("sat_fidx", s_fidx, 0);

        // Asynchronous reset in the middle of RUN, then a clean window.
        cycle(1, 0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0, 4'h8);
        check("mid_busy", busy, 1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(i == 0, i == 4, 4'h7, 4'h7);

        // Restart in RUN after three mismatches.
        for (int i = 0; i < 3; i++) cycle(i == 0, 0, 4'h1, 4'h0);
        check("rs_pre_errors", errors, 3);
        cycle(1, 0, 4'h1, 4'h1);
        check("rs_busy", busy, 1);
        check("rs_clocks", clocks, 1);
        check("rs_errors", errors, 0);
        check("rs_fev", fev, 0);
        cycle(0, 0, 4'h1, 4'h1);
        check("rs_fev_hold", fev, 0);
        cycle(0, 0, 4'h1, 4'h1);
        cycle(0, 0, 4'h1, 4'h3);
        check("rs_fev_set", fev, 1);
        cycle(0, 1, 4'h1, 4'h1);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
